// File: rtl/senone_normaliser.sv
// Collects one frame of senone scores and then streams score minus frame maximum, saturated to 16 bits.
// Scores land one cycle after the pulse; the drain sends one output per cycle and holds while out_ready is low.
module senone_normaliser #(
    parameter int N_SENONES = 10,
    parameter int IDX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 score_ready,
    input  logic [IDX_WIDTH-1:0] senone_idx,
    input  logic [15:0]          senone_score,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic [15:0]          out_score,
    output logic [15:0]          max_score,
    output logic                 frame_done,
    output logic                 err_range,
    output logic                 err_dup,
    output logic                 err_overrun
);

    typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

    state_t                      state_q, state_d;
    logic signed [15:0]          buf_q [N_SENONES];
    logic signed [15:0]          buf_d [N_SENONES];
    logic [N_SENONES-1:0]        wr_mask_q, wr_mask_d;
    logic [IDX_WIDTH-1:0]        rd_ptr_q, rd_ptr_d;
    logic signed [15:0]          max_q, max_d;
    logic                        frame_done_q, frame_done_d;
    logic                        err_range_q, err_range_d;
    logic                        err_dup_q, err_dup_d;
    logic                        err_overrun_q, err_overrun_d;
    logic signed [15:0]          rd_val;
    logic signed [16:0]          diff;
    logic [15:0]                 sat_val;

    // Read mux and 17-bit subtract with clamp to the num range.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_SENONES; i++) begin
            if (rd_ptr_q == IDX_WIDTH'(i)) begin
                rd_val = buf_q[i];
            end
        end
        diff = {rd_val[15], rd_val} - {max_q[15], max_q};
        if (diff < -17'sd32768) begin
            sat_val = 16'h8000;
        end else if (diff > 17'sd32767) begin
            sat_val = 16'h7fff;
        end else begin
            sat_val = diff[15:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        wr_mask_d     = wr_mask_q;
        rd_ptr_d      = rd_ptr_q;
        max_d         = max_q;
        frame_done_d  = 1'b0;
        err_range_d   = err_range_q;
        err_dup_d     = err_dup_q;
        err_overrun_d = err_overrun_q;
        case (state_q)
            COLLECT: begin
                if (score_ready) begin
                    if (senone_idx >= IDX_WIDTH'(N_SENONES)) begin
                        err_range_d = 1'b1;
                    end else begin
                        for (int i = 0; i < N_SENONES; i++) begin
                            if (senone_idx == IDX_WIDTH'(i)) begin
                                buf_d[i] = $signed(senone_score);
                                if (wr_mask_q[i]) begin
                                    err_dup_d = 1'b1;
                                end
                                wr_mask_d[i] = 1'b1;
                            end
                        end
                        if ($signed(senone_score) > max_q) begin
                            max_d = $signed(senone_score);
                        end
                        if (&wr_mask_d) begin
                            state_d  = DRAIN;
                            rd_ptr_d = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                if (score_ready) begin
                    err_overrun_d = 1'b1;
                end
                if (out_ready) begin
                    if (rd_ptr_q == IDX_WIDTH'(N_SENONES - 1)) begin
                        state_d      = COLLECT;
                        rd_ptr_d     = '0;
                        wr_mask_d    = '0;
                        max_d        = 16'sh8000;
                        frame_done_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= COLLECT;
            for (int i = 0; i < N_SENONES; i++) begin
                buf_q[i] <= '0;
            end
            wr_mask_q     <= '0;
            rd_ptr_q      <= '0;
            max_q         <= 16'sh8000;
            frame_done_q  <= 1'b0;
            err_range_q   <= 1'b0;
            err_dup_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            wr_mask_q     <= wr_mask_d;
            rd_ptr_q      <= rd_ptr_d;
            max_q         <= max_d;
            frame_done_q  <= frame_done_d;
            err_range_q   <= err_range_d;
            err_dup_q     <= err_dup_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign busy        = (state_q == DRAIN);
    assign out_valid   = (state_q == DRAIN);
    assign out_idx     = (state_q == DRAIN) ? rd_ptr_q : '0;
    assign out_score   = (state_q == DRAIN) ? sat_val : 16'h0000;
    assign max_score   = max_q;
    assign frame_done  = frame_done_q;
    assign err_range   = err_range_q;
    assign err_dup     = err_dup_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_senone_normaliser.sv
// Bench for senone_normaliser: frame-level reference model with a per-cycle compare plus literal expectations.
module tb_senone_normaliser;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        score_ready = 1'b0;
    logic [7:0]  senone_idx = '0;
    logic [15:0] senone_score = '0;
    logic        out_ready = 1'b0;
    logic        busy, out_valid, frame_done, err_range, err_dup, err_overrun;
    logic [7:0]  out_idx;
    logic [15:0] out_score, max_score;

    always #5 clk = ~clk;

    senone_normaliser #(.N_SENONES(N), .IDX_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .score_ready(score_ready),
        .senone_idx(senone_idx), .senone_score(senone_score),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_score(out_score), .max_score(max_score),
        .frame_done(frame_done), .err_range(err_range), .err_dup(err_dup),
        .err_overrun(err_overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a frame is a set of written scores; once complete it becomes a queue of outputs.
    typedef struct {
        int idx;
        int sc;
    } out_t;

    out_t m_q[$];
    int   m_vals[N];
    bit   m_wr[N];
    bit   m_drain = 1'b0;
    int   m_max = -32768;
    bit   m_er = 1'b0, m_ed = 1'b0, m_eo = 1'b0, m_fd = 1'b0;
    int   m_k, m_d;
    bit   m_all;
    out_t m_e;

    always @(posedge clk) begin
        if (!reset) begin
            m_drain = 1'b0;
            m_q.delete();
            for (int i = 0; i < N; i++) m_wr[i] = 1'b0;
            m_max = -32768;
            m_er = 1'b0; m_ed = 1'b0; m_eo = 1'b0; m_fd = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (m_drain) begin
                if (score_ready) m_eo = 1'b1;
                if (out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_drain = 1'b0;
                        m_fd = 1'b1;
                        m_max = -32768;
                        for (int i = 0; i < N; i++) m_wr[i] = 1'b0;
                    end
                end
            end else if (score_ready) begin
                m_k = int'(senone_idx);
                if (m_k >= N) begin
                    m_er = 1'b1;
                end else begin
                    if (m_wr[m_k]) m_ed = 1'b1;
                    m_vals[m_k] = int'($signed(senone_score));
                    m_wr[m_k] = 1'b1;
                    if (m_vals[m_k] > m_max) m_max = m_vals[m_k];
                    m_all = 1'b1;
                    for (int i = 0; i < N; i++) if (!m_wr[i]) m_all = 1'b0;
                    if (m_all) begin
                        for (int i = 0; i < N; i++) begin
                            m_d = m_vals[i] - m_max;
                            if (m_d < -32768) m_d = -32768;
                            if (m_d > 32767) m_d = 32767;
                            m_e.idx = i;
                            m_e.sc = m_d;
                            m_q.push_back(m_e);
                        end
                        m_drain = 1'b1;
                    end
                end
            end
        end
    end

    bit mon_en = 1'b0;
    int log_n = 0;
    int log_idx[64];
    int log_sc[64];

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", int'(busy), int'(m_drain));
            chk("out_valid", int'(out_valid), int'(m_drain));
            if (m_drain) begin
                chk("out_idx", int'(out_idx), m_q[0].idx);
                chk("out_score", int'($signed(out_score)), m_q[0].sc);
                if (out_ready && log_n < 64) begin
                    log_idx[log_n] = int'(out_idx);
                    log_sc[log_n] = int'($signed(out_score));
                    log_n++;
                end
            end else begin
                chk("out_idx_idle", int'(out_idx), 0);
                chk("out_score_idle", int'($signed(out_score)), 0);
            end
            chk("max_score", int'($signed(max_score)), m_max);
            chk("frame_done", int'(frame_done), int'(m_fd));
            chk("err_range", int'(err_range), int'(m_er));
            chk("err_dup", int'(err_dup), int'(m_ed));
            chk("err_overrun", int'(err_overrun), int'(m_eo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input int sc);
        score_ready = 1'b1;
        senone_idx = idx[7:0];
        senone_score = sc[15:0];
        tick();
        score_ready = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 200) begin
            tick();
            n++;
        end
        chk("frame_done_timeout", int'(frame_done), 1);
    endtask

    task automatic check_log(input string name, input int exp_sc[N]);
        chk({name, "_count"}, log_n, N);
        for (int i = 0; i < N; i++) begin
            chk({name, "_idx"}, log_idx[i], i);
            chk({name, "_score"}, log_sc[i], exp_sc[i]);
        end
    endtask

    int s1[N] = '{100, -200, 300, 50, 0, -1, 7, 299, -300, 10};
    int e1[N] = '{-200, -500, 0, -250, -300, -301, -293, -1, -600, -290};
    int e2[N] = '{0, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    int e4[N] = '{-9, -8, -7, -1, -5, -4, -3, -2, -1, 0};

    initial begin
        tick();
        mon_en = 1'b1;
        tick();
        chk("reset_max", int'($signed(max_score)), -32768);
        chk("reset_valid", int'(out_valid), 0);
        reset = 1'b1;

        // Basic frame with out_ready held high
        out_ready = 1'b1;
        log_n = 0;
        for (int i = 0; i < N; i++) send(i, s1[i]);
        chk("t1_max", int'($signed(max_score)), 300);
        chk("t1_busy", int'(busy), 1);
        wait_done();
        check_log("t1", e1);

        // Saturation at the bottom of the range
        log_n = 0;
        send(0, 32767);
        for (int i = 1; i < N; i++) send(i, -32768);
        wait_done();
        check_log("t2", e2);

        // Reverse-order writes, stalled drain
        out_ready = 1'b0;
        log_n = 0;
        for (int i = N - 1; i >= 0; i--) send(i, s1[i]);
        for (int k = 0; k < 200 && !frame_done; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        chk("t3_done", int'(frame_done), 1);
        check_log("t3", e1);

        // Range error, duplicate overwrite
        out_ready = 1'b1;
        log_n = 0;
        send(12, 999);
        send(3, 5);
        send(3, 8);
        for (int i = 0; i < N; i++) if (i != 3) send(i, i);
        chk("t4_err_range", int'(err_range), 1);
        chk("t4_err_dup", int'(err_dup), 1);
        chk("t4_max", int'($signed(max_score)), 9);
        wait_done();
        check_log("t4", e4);

        // Overrun during drain, then a pulse in the frame_done cycle
        log_n = 0;
        for (int i = 0; i < N; i++) send(i, s1[i]);
        send(0, 1000);
        chk("t5_err_overrun", int'(err_overrun), 1);
        wait_done();
        check_log("t5", e1);
        send(5, 77);
        chk("t5_next_max", int'($signed(max_score)), 77);
        chk("t5_next_busy", int'(busy), 0);

        // Reset mid-frame and mid-drain
        for (int i = 0; i < 4; i++) send(i, 40 + i);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_max", int'($signed(max_score)), -32768);
        chk("t6_err_range", int'(err_range), 0);
        chk("t6_err_dup", int'(err_dup), 0);
        chk("t6_err_overrun", int'(err_overrun), 0);
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(i, s1[i]);
        tick();
        chk("t6_drain_valid", int'(out_valid), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_reset_valid", int'(out_valid), 0);
        chk("t6_reset_busy", int'(busy), 0);
        out_ready = 1'b1;
        log_n = 0;
        for (int i = 0; i < N; i++) send(i, s1[i]);
        wait_done();
        check_log("t6", e1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
